mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles in ACCESS without dmem_ack before abort; used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite  in  1 each  control bits from the EX/MEM register.
REQ-005 EXtoMEM_zero  in  1  ALU zero flag.
REQ-006 EXtoMEM_ALUresult  in  32  data address, or result to forward.
REQ-007 EXtoMEM_Rt  in  32  store data.
REQ-008 EXtoMEM_Branch_Addr  in  32  branch target.
REQ-009 EXtoMEM_RegDest  in  5  destination register number, taken from the low 5 bits of the EX/MEM field.
REQ-010 dmem_req, dmem_we  out  1  memory request and write-enable.
REQ-011 dmem_addr, dmem_wdata  out  32  memory address and store data.
REQ-012 dmem_rdata  in  32  load data; dmem_ack  in  1  access complete, valid for one cycle.
REQ-013 PCSrc  out  1  branch taken; branch_target  out  32  branch target.
REQ-014 mem_stall  out  1  hold request to the IF/ID/EX stages and the EX/MEM register.
REQ-015 MEMtoWB_ReadData, MEMtoWB_ALUresult  out  32; MEMtoWB_RegDest  out  5; WB_MemtoReg, WB_RegWrite  out  1. These form the MEM/WB register.
REQ-016 mem_err  out  1  sticky timeout flag.

Function
REQ-017 PCSrc SHALL equal MEM_Branch & EXtoMEM_zero and branch_target SHALL equal EXtoMEM_Branch_Addr; both combinational.
REQ-018 The FSM SHALL have two states, IDLE and ACCESS; it SHALL reset to IDLE.
REQ-019 In IDLE with MemRead|MemWrite=1, the block SHALL register addr=ALUresult, wdata=Rt and we=MemWrite, SHALL go to ACCESS, and SHALL assert mem_stall combinationally in that cycle.
REQ-020 In ACCESS, dmem_req SHALL be 1 and addr/wdata/we SHALL hold stable. mem_stall SHALL be 1 until the cycle in which dmem_ack=1.
REQ-021 In the ack cycle, mem_stall SHALL be 0. At that edge the block SHALL load MEM/WB with ReadData=dmem_rdata (zero for a write) and the current EX/MEM fields, and SHALL return to IDLE.
REQ-022 Minimum memory instruction occupancy SHALL be 2 cycles (1 IDLE + ≥1 ACCESS).
REQ-023 While mem_stall=1, MEM/WB SHALL load a bubble: WB_RegWrite=0, WB_MemtoReg=0, other fields unchanged.
REQ-024 A non-memory instruction SHALL pass into MEM/WB in 1 cycle with ReadData=0 and no stall.
REQ-025 If MemRead and MemWrite are both 1, the access SHALL be a write and ReadData SHALL be 0.
REQ-026 dmem_ack while in IDLE SHALL be ignored.
REQ-027 dmem_req SHALL be 0 in IDLE.

Reset
REQ-028 rst=0 at a posedge SHALL force IDLE and clear every registered output to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, all MEM/WB fields, mem_err and the timeout counter.
REQ-029 rst=0 during ACCESS SHALL drop dmem_req the next cycle. A late dmem_ack after reset SHALL be ignored per REQ-026.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack. On reaching TIMEOUT_CYCLES, the block SHALL:
- deassert dmem_req and return to IDLE;
- set mem_err=1 until reset;
- drop mem_stall that cycle;
- load MEM/WB with a bubble.
REQ-031 Without MEM_TIMEOUT_EN, there SHALL be no counter, ACCESS SHALL wait indefinitely for ack, and mem_err SHALL be constant 0.

Verification
REQ-032 Load: MemRead=1, ALUresult=0x40, RegWrite=1, ack on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> mem_stall=1 for 3 cycles; MEM/WB then ReadData=0xDEADBEEF, WB_RegWrite=1; bubbles during the stall.
REQ-033 Store: MemWrite=1, ALUresult=0x80, Rt=0x1234, ack after 1 cycle -> dmem_we=1, addr=0x80, wdata=0x1234 stable while req=1; WB_RegWrite=0.
REQ-034 Branch: MEM_Branch=1, zero=1, Branch_Addr=0x100 -> PCSrc=1, branch_target=0x100 the same cycle, no stall; zero=0 -> PCSrc=0.
REQ-035 Reset mid-access: rst=0 in the 2nd ACCESS cycle, ack the next cycle -> IDLE, dmem_req=0, all outputs 0, ack ignored.
REQ-036 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack) -> req drops after 4 ACCESS cycles, mem_err=1 and stays 1, bubble in MEM/WB; without the macro, stall persists with mem_err=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-outstanding data-memory handshake, branch resolve and MEM/WB register.
// Optional access timeout with sticky error flag is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Branch,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic        EXtoMEM_zero,
  input  logic [31:0] EXtoMEM_ALUresult,
  input  logic [31:0] EXtoMEM_Rt,
  input  logic [31:0] EXtoMEM_Branch_Addr,
  input  logic [4:0]  EXtoMEM_RegDest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic [31:0] MEMtoWB_ReadData,
  output logic [31:0] MEMtoWB_ALUresult,
  output logic [4:0]  MEMtoWB_RegDest,
  output logic        WB_MemtoReg,
  output logic        WB_RegWrite,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;

  logic mem_op, tmo_hit;

  assign mem_op        = MEM_MemRead | MEM_MemWrite;
  assign PCSrc         = MEM_Branch & EXtoMEM_zero;
  assign branch_target = EXtoMEM_Branch_Addr;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // Abort fires in the last allowed ACCESS cycle; an ack in that same cycle still wins.
  assign tmo_hit = (state == ACCESS) && !dmem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE || tmo_hit) tmo_cnt <= '0;
      else if (!dmem_ack)           tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE) mem_stall = mem_op;
    else               mem_stall = !(dmem_ack | tmo_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      MEMtoWB_ReadData  <= '0;
      MEMtoWB_ALUresult <= '0;
      MEMtoWB_RegDest   <= '0;
      WB_MemtoReg       <= 1'b0;
      WB_RegWrite       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_op) begin
          state      <= ACCESS;
          dmem_req   <= 1'b1;
          dmem_addr  <= EXtoMEM_ALUresult;
          dmem_wdata <= EXtoMEM_Rt;
          dmem_we    <= MEM_MemWrite;
        end
        ACCESS: if (dmem_ack || tmo_hit) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Stalled or aborted cycles push a bubble; data fields keep their last value.
      if (mem_stall || tmo_hit) begin
        WB_MemtoReg <= 1'b0;
        WB_RegWrite <= 1'b0;
      end else begin
        MEMtoWB_ReadData  <= (state == ACCESS && dmem_ack && !dmem_we) ? dmem_rdata : 32'd0;
        MEMtoWB_ALUresult <= EXtoMEM_ALUresult;
        MEMtoWB_RegDest   <= EXtoMEM_RegDest;
        WB_MemtoReg       <= MEM_MemtoReg;
        WB_RegWrite       <= MEM_RegWrite;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage; expectations come from transaction-level rules.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
  logic        EXtoMEM_zero;
  logic [31:0] EXtoMEM_ALUresult, EXtoMEM_Rt, EXtoMEM_Branch_Addr;
  logic [4:0]  EXtoMEM_RegDest;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        mem_stall;
  logic [31:0] MEMtoWB_ReadData, MEMtoWB_ALUresult;
  logic [4:0]  MEMtoWB_RegDest;
  logic        WB_MemtoReg, WB_RegWrite, mem_err;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .MEM_Branch(MEM_Branch), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
    .EXtoMEM_zero(EXtoMEM_zero), .EXtoMEM_ALUresult(EXtoMEM_ALUresult),
    .EXtoMEM_Rt(EXtoMEM_Rt), .EXtoMEM_Branch_Addr(EXtoMEM_Branch_Addr),
    .EXtoMEM_RegDest(EXtoMEM_RegDest),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .PCSrc(PCSrc), .branch_target(branch_target), .mem_stall(mem_stall),
    .MEMtoWB_ReadData(MEMtoWB_ReadData), .MEMtoWB_ALUresult(MEMtoWB_ALUresult),
    .MEMtoWB_RegDest(MEMtoWB_RegDest), .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected MEM/WB contents and error flag
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_dst;
  logic        e_m2r, e_rw, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, ".rdata"}, MEMtoWB_ReadData, e_rd);
    chk({tag, ".alu"},   MEMtoWB_ALUresult, e_alu);
    chk({tag, ".dest"},  {27'd0, MEMtoWB_RegDest}, {27'd0, e_dst});
    chk({tag, ".m2r"},   {31'd0, WB_MemtoReg}, {31'd0, e_m2r});
    chk({tag, ".rw"},    {31'd0, WB_RegWrite}, {31'd0, e_rw});
    chk({tag, ".err"},   {31'd0, mem_err}, {31'd0, e_err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic br, input logic z, input logic rd, input logic wr,
                        input logic m2r, input logic rw, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [31:0] ba, input logic [4:0] dst);
    MEM_Branch = br; EXtoMEM_zero = z; MEM_MemRead = rd; MEM_MemWrite = wr;
    MEM_MemtoReg = m2r; MEM_RegWrite = rw; EXtoMEM_ALUresult = alu;
    EXtoMEM_Rt = rt; EXtoMEM_Branch_Addr = ba; EXtoMEM_RegDest = dst;
  endtask

  task automatic bubble();
    e_rw = 1'b0;
    e_m2r = 1'b0;
  endtask

  task automatic retire(input logic [31:0] rdat);
    e_rd  = rdat;
    e_alu = EXtoMEM_ALUresult;
    e_dst = EXtoMEM_RegDest;
    e_m2r = MEM_MemtoReg;
    e_rw  = MEM_RegWrite;
  endtask

  // Runs the instruction currently on the EX/MEM inputs; ack arrives in ACCESS cycle 'lat'.
  task automatic do_op(input string tag, input int lat, input logic [31:0] rdat);
    logic mem, w;
    mem = MEM_MemRead | MEM_MemWrite;
    w   = MEM_MemWrite;
    #4;
    chk({tag, ".pcsrc"}, {31'd0, PCSrc}, {31'd0, MEM_Branch & EXtoMEM_zero});
    chk({tag, ".btgt"}, branch_target, EXtoMEM_Branch_Addr);
    chk({tag, ".stall0"}, {31'd0, mem_stall}, {31'd0, mem});
    chk({tag, ".req_idle"}, {31'd0, dmem_req}, 32'd0);
    if (!mem) begin
      step();
      retire(32'd0);
      chk_wb({tag, ".wb"});
      chk({tag, ".req_after"}, {31'd0, dmem_req}, 32'd0);
      dmem_ack = 1'b0;
      return;
    end
    step();
    bubble();
    chk_wb({tag, ".wb_b0"});
    for (int k = 1; k <= lat; k++) begin
      dmem_ack   = (k == lat);
      dmem_rdata = (k == lat) ? rdat : $urandom;
      #3;
      chk({tag, ".stall"}, {31'd0, mem_stall}, {31'd0, k != lat});
      chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, w});
      chk({tag, ".addr"}, dmem_addr, EXtoMEM_ALUresult);
      chk({tag, ".wdata"}, dmem_wdata, EXtoMEM_Rt);
      step();
      if (k < lat) bubble();
      else retire(w ? 32'd0 : rdat);
      chk_wb({tag, ".wb"});
    end
    dmem_ack = 1'b0;
    chk({tag, ".req_done"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    e_rd = '0; e_alu = '0; e_dst = '0; e_m2r = 1'b0; e_rw = 1'b0; e_err = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 32'h66, 32'h77, 5'd3);
    step();
    step();
    chk("rst.req", {31'd0, dmem_req}, 32'd0);
    chk("rst.we", {31'd0, dmem_we}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk_wb("rst");
    rst = 1'b1;

    // Load, ack in 3rd ACCESS cycle
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 32'h0, 5'd7);
    do_op("load", 3, 32'hDEADBEEF);
    // Store, ack in 1st ACCESS cycle
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234, 32'h0, 5'd0);
    do_op("store", 1, 32'hCAFEF00D);
    // Read+write together behaves as a write
    set_ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC0, 32'hABCD, 32'h0, 5'd9);
    do_op("rdwr", 2, 32'h11112222);
    // Branch taken / not taken
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 32'h100, 5'd1);
    do_op("br_t", 1, 32'h0);
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0, 32'h100, 5'd1);
    do_op("br_nt", 1, 32'h0);
    // Stray ack while idle is ignored
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 32'h0, 5'd4);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    do_op("idle_ack", 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      set_ex(1'($urandom), 1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
             1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      dmem_ack = (kind == 0) ? 1'($urandom) : 1'b0;
      dmem_rdata = $urandom;
      do_op("rnd", $urandom_range(1, TMO), $urandom);
    end

    // Reset in 2nd ACCESS cycle, ack arrives after reset
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 32'h0, 5'd12);
    #4;
    chk("rma.stall", {31'd0, mem_stall}, 32'd1);
    step();
    step();
    chk("rma.req_acc2", {31'd0, dmem_req}, 32'd1);
    rst = 1'b0;
    step();
    e_rd = '0; e_alu = '0; e_dst = '0; e_m2r = 1'b0; e_rw = 1'b0; e_err = 1'b0;
    chk("rma.req", {31'd0, dmem_req}, 32'd0);
    chk("rma.addr", dmem_addr, 32'd0);
    chk("rma.we", {31'd0, dmem_we}, 32'd0);
    chk_wb("rma");
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h87654321;
    do_op("rma_ack", 1, 32'h0);

    // Access that never gets an ack
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 32'h0, 5'd21);
    #4;
    chk("tmo.stall0", {31'd0, mem_stall}, 32'd1);
    step();
    bubble();
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      #3;
      chk("tmo.stall", {31'd0, mem_stall}, {31'd0, k != TMO});
      chk("tmo.req", {31'd0, dmem_req}, 32'd1);
      step();
      bubble();
      if (k == TMO) e_err = 1'b1;
      chk_wb("tmo.wb");
    end
    chk("tmo.req_drop", {31'd0, dmem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom, 5'($urandom));
      do_op("tmo.after", 1, 32'h0);
    end
    rst = 1'b0;
    step();
    e_rd = '0; e_alu = '0; e_dst = '0; e_m2r = 1'b0; e_rw = 1'b0; e_err = 1'b0;
    chk_wb("tmo.rst");
    rst = 1'b1;
`else
    for (int k = 1; k <= 2 * TMO; k++) begin
      #3;
      chk("wait.stall", {31'd0, mem_stall}, 32'd1);
      chk("wait.req", {31'd0, dmem_req}, 32'd1);
      step();
      bubble();
      chk_wb("wait.wb");
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    #3;
    chk("wait.stall_ack", {31'd0, mem_stall}, 32'd0);
    step();
    retire(32'h0BADF00D);
    dmem_ack = 1'b0;
    chk_wb("wait.done");
    chk("wait.req_done", {31'd0, dmem_req}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
